// File: rtl/chan_pkg.sv
// Shared channel types: injection modes, burst FSM states, LFSR polynomial and seed helpers.
// Symbols are 2 bits wide; the LFSR is a 16-bit Galois register that never reaches zero.
package chan_pkg;

  localparam int          SYM_W         = 2;
  localparam logic [15:0] LFSR_POLY     = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'd0,
    MODE_WINDOW = 2'd1,
    MODE_BURST  = 2'd2,
    MODE_RANDOM = 2'd3
  } mode_e;

  typedef enum logic {
    ST_GAP = 1'b0,
    ST_HIT = 1'b1
  } burst_st_e;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_POLY : 16'h0000);
  endfunction

  // An all-zero seed would lock the LFSR, so it is promoted to 1.
  function automatic logic [15:0] seed_fix(input logic [15:0] s);
    return (s == 16'h0000) ? 16'h0001 : s;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR; load wins over advance, and load+advance yields one step past the seed.
// q exposes the low OUT_W bits of the state; 1-cycle update, no backpressure.
module lfsr16
  import chan_pkg::*;
#(
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [15:0]      seed,
  input  logic             advance,
  output logic [OUT_W-1:0] q
);

  logic [15:0] state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= seed;
    end else if (load) begin
      state <= advance ? lfsr_step(seed) : seed;
    end else if (advance) begin
      state <= lfsr_step(state);
    end
  end

  assign q = state[OUT_W-1:0];

endmodule

// File: rtl/channel_err_inj.sv
// Channel error injector: inverts masked bits of encoder symbols in PASS/WINDOW/BURST/RANDOM modes.
// Registered output, 1-cycle latency; no backpressure, gap cycles hold sym_o and zero err_o.
module channel_err_inj
  import chan_pkg::*;
#(
  parameter int          CNT_W     = 16,
  parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             sym_valid_i,
  input  logic [SYM_W-1:0] sym_i,
  input  logic [1:0]       mode_i,
  input  logic [SYM_W-1:0] mask_i,
  input  logic [7:0]       period_i,
  input  logic [7:0]       burst_len_i,
  input  logic [7:0]       thresh_i,
  output logic             sym_valid_o,
  output logic [SYM_W-1:0] sym_o,
  output logic [SYM_W-1:0] err_o,
  output logic [CNT_W-1:0] sym_cnt_o,
  output logic [CNT_W-1:0] flip_cnt_o
);

  localparam logic [15:0] SEED = seed_fix(LFSR_SEED);

  logic [7:0]       phase_q, phase_cur, phase_nxt, period_m1, lfsr_q, lfsr_cur;
  burst_st_e        state_q, state_nxt;
  logic [SYM_W-1:0] e;
  logic [CNT_W-1:0] sym_base, flip_base, sym_cnt_nxt, flip_cnt_nxt;
  logic [CNT_W:0]   flip_sum;
  logic [1:0]       pop;

  lfsr16 #(.OUT_W(8)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (start_i),
    .seed    (SEED),
    .advance (sym_valid_i),
    .q       (lfsr_q)
  );

  // A start pulse makes the current symbol index 0 with a freshly seeded LFSR.
  assign phase_cur = start_i ? 8'd0 : phase_q;
  assign lfsr_cur  = start_i ? SEED[7:0] : lfsr_q;
  assign period_m1 = period_i - 8'd1;

  always_comb begin
    e         = '0;
    state_nxt = start_i ? ST_GAP : state_q;
    phase_nxt = phase_cur;
    if (sym_valid_i) begin
      case (mode_e'(mode_i))
        MODE_WINDOW: if (phase_cur < burst_len_i) e = mask_i;
        MODE_BURST: begin
          state_nxt = (phase_cur < burst_len_i) ? ST_HIT : ST_GAP;
          if (state_nxt == ST_HIT) e = mask_i;
        end
        MODE_RANDOM: if (lfsr_cur < thresh_i) e = mask_i;
        default: ;
      endcase
      // >= keeps the phase bounded if the period shrinks below the current phase.
      if (mode_e'(mode_i) == MODE_WINDOW) begin
        phase_nxt = (phase_cur == 8'hFF) ? phase_cur : phase_cur + 8'd1;
      end else begin
        phase_nxt = (phase_cur >= period_m1) ? 8'd0 : phase_cur + 8'd1;
      end
    end
  end

  always_comb begin
    sym_base     = start_i ? '0 : sym_cnt_o;
    flip_base    = start_i ? '0 : flip_cnt_o;
    pop          = {1'b0, e[0]} + {1'b0, e[1]};
    flip_sum     = {1'b0, flip_base} + {{(CNT_W-1){1'b0}}, pop};
    sym_cnt_nxt  = sym_base;
    flip_cnt_nxt = flip_base;
    if (sym_valid_i) begin
      sym_cnt_nxt  = (sym_base == '1) ? sym_base : sym_base + CNT_W'(1);
      flip_cnt_nxt = flip_sum[CNT_W] ? '1 : flip_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sym_valid_o <= 1'b0;
      sym_o       <= '0;
      err_o       <= '0;
      sym_cnt_o   <= '0;
      flip_cnt_o  <= '0;
      phase_q     <= 8'd0;
      state_q     <= ST_GAP;
    end else begin
      sym_valid_o <= sym_valid_i;
      err_o       <= e;
      if (sym_valid_i) sym_o <= sym_i ^ e;
      sym_cnt_o   <= sym_cnt_nxt;
      flip_cnt_o  <= flip_cnt_nxt;
      phase_q     <= phase_nxt;
      state_q     <= state_nxt;
    end
  end

endmodule

// File: tb/tb_channel_err_inj.sv
// Directed bench for channel_err_inj: window, burst, gapped valid, random, boundaries, reset/start.
module tb_channel_err_inj;

  logic        clk = 1'b0;
  logic        rst, start_i, sym_valid_i;
  logic [1:0]  sym_i, mode_i, mask_i;
  logic [7:0]  period_i, burst_len_i, thresh_i;
  logic        sym_valid_o;
  logic [1:0]  sym_o, err_o;
  logic [15:0] sym_cnt_o, flip_cnt_o;

  int errors = 0;
  int checks = 0;

  channel_err_inj dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .sym_valid_i (sym_valid_i),
    .sym_i       (sym_i),
    .mode_i      (mode_i),
    .mask_i      (mask_i),
    .period_i    (period_i),
    .burst_len_i (burst_len_i),
    .thresh_i    (thresh_i),
    .sym_valid_o (sym_valid_o),
    .sym_o       (sym_o),
    .err_o       (err_o),
    .sym_cnt_o   (sym_cnt_o),
    .flip_cnt_o  (flip_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    start_i     = 1'b1;
    sym_valid_i = 1'b0;
    tick();
    start_i     = 1'b0;
  endtask

  function automatic logic [15:0] ref_step(input logic [15:0] s);
    logic [15:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  logic [15:0] ref_lfsr;
  int          ref_flips;

  initial begin
    rst = 1'b1; start_i = 1'b0; sym_valid_i = 1'b1; sym_i = 2'b11;
    mode_i = 2'd2; mask_i = 2'b11; period_i = 8'd5; burst_len_i = 8'd2; thresh_i = 8'd0;
    tick();
    tick();
    check("rst_valid", sym_valid_o, 0);
    check("rst_sym", sym_o, 0);
    check("rst_err", err_o, 0);
    check("rst_symcnt", sym_cnt_o, 0);
    check("rst_flipcnt", flip_cnt_o, 0);
    rst = 1'b0; sym_valid_i = 1'b0;
    tick();

    // WINDOW: first 4 symbols get bit 1 inverted
    mode_i = 2'd1; mask_i = 2'b10; burst_len_i = 8'd4;
    restart();
    for (int i = 0; i < 10; i++) begin
      sym_valid_i = 1'b1; sym_i = 2'b11;
      tick();
      check($sformatf("win_sym%0d", i), sym_o, (i < 4) ? 2'b01 : 2'b11);
    end
    sym_valid_i = 1'b0;
    check("win_flipcnt", flip_cnt_o, 4);
    check("win_symcnt", sym_cnt_o, 10);

    // BURST: period 5, 2 hits per period
    mode_i = 2'd2; mask_i = 2'b11; period_i = 8'd5; burst_len_i = 8'd2;
    restart();
    for (int i = 0; i < 12; i++) begin
      sym_valid_i = 1'b1; sym_i = 2'b00;
      tick();
      check($sformatf("burst_err%0d", i), err_o, ((i % 5) < 2) ? 2'b11 : 2'b00);
    end
    sym_valid_i = 1'b0;
    check("burst_flipcnt", flip_cnt_o, 12);

    // Gapped valid: phase advances only on valid cycles
    restart();
    sym_i = 2'b00;
    sym_valid_i = 1'b1; tick();
    check("gap_v0", sym_valid_o, 1); check("gap_e0", err_o, 2'b11);
    sym_valid_i = 1'b0; tick();
    check("gap_v1", sym_valid_o, 0); check("gap_e1", err_o, 0); check("gap_hold1", sym_o, 2'b11);
    sym_valid_i = 1'b1; tick();
    check("gap_v2", sym_valid_o, 1); check("gap_e2", err_o, 2'b11);
    sym_valid_i = 1'b0; tick();
    check("gap_e3", err_o, 0);
    sym_valid_i = 1'b1; tick();
    check("gap_e4", err_o, 2'b00); check("gap_sym4", sym_o, 2'b00);
    sym_valid_i = 1'b0; tick();
    check("gap_v5", sym_valid_o, 0);
    check("gap_symcnt", sym_cnt_o, 3);

    // RANDOM thresh 0: no errors
    mode_i = 2'd3; mask_i = 2'b11; thresh_i = 8'd0;
    restart();
    sym_valid_i = 1'b1; sym_i = 2'b10;
    repeat (1000) tick();
    sym_valid_i = 1'b0;
    check("rnd0_flipcnt", flip_cnt_o, 0);
    check("rnd0_symcnt", sym_cnt_o, 1000);

    // RANDOM thresh 255 against reference LFSR
    mask_i = 2'b01; thresh_i = 8'd255;
    ref_lfsr = 16'hACE1; ref_flips = 0;
    for (int i = 0; i < 1000; i++) begin
      if (ref_lfsr[7:0] < 8'd255) ref_flips++;
      ref_lfsr = ref_step(ref_lfsr);
    end
    restart();
    sym_valid_i = 1'b1; sym_i = 2'b00;
    tick();
    check("rnd255_first", err_o, 2'b01);
    repeat (999) tick();
    sym_valid_i = 1'b0;
    check("rnd255_flipcnt", flip_cnt_o, ref_flips);

    // burst_len >= period: every symbol corrupted
    mode_i = 2'd2; mask_i = 2'b11; period_i = 8'd4; burst_len_i = 8'd8;
    restart();
    for (int i = 0; i < 9; i++) begin
      sym_valid_i = 1'b1; sym_i = 2'b01;
      tick();
      check($sformatf("full_sym%0d", i), sym_o, 2'b10);
    end
    sym_valid_i = 1'b0;
    check("full_flipcnt", flip_cnt_o, 18);

    // period 0 means 256
    mask_i = 2'b01; period_i = 8'd0; burst_len_i = 8'd1;
    restart();
    for (int i = 0; i < 512; i++) begin
      sym_valid_i = 1'b1; sym_i = 2'b00;
      tick();
      if (i == 0 || i == 1 || i == 255 || i == 256)
        check($sformatf("p256_err%0d", i), err_o, (i == 0 || i == 256) ? 2'b01 : 2'b00);
    end
    sym_valid_i = 1'b0;
    check("p256_flipcnt", flip_cnt_o, 2);
    check("p256_symcnt", sym_cnt_o, 512);

    // Reset mid-burst overrides start and drops pending output
    mask_i = 2'b11; period_i = 8'd5; burst_len_i = 8'd2;
    restart();
    sym_valid_i = 1'b1; sym_i = 2'b00;
    tick();
    check("mid_err", err_o, 2'b11);
    rst = 1'b1; start_i = 1'b1;
    tick();
    check("mid_rst_valid", sym_valid_o, 0);
    check("mid_rst_sym", sym_o, 0);
    check("mid_rst_err", err_o, 0);
    check("mid_rst_symcnt", sym_cnt_o, 0);
    check("mid_rst_flipcnt", flip_cnt_o, 0);
    rst = 1'b0; start_i = 1'b0; sym_valid_i = 1'b0;
    tick();

    // start_i with valid restarts the window at index 0
    mode_i = 2'd1; mask_i = 2'b10; burst_len_i = 8'd2;
    sym_valid_i = 1'b1; sym_i = 2'b11;
    repeat (3) tick();
    check("st_pre_sym", sym_o, 2'b11);
    check("st_pre_flip", flip_cnt_o, 2);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("st_symcnt", sym_cnt_o, 1);
    check("st_sym0", sym_o, 2'b01);
    check("st_flip", flip_cnt_o, 1);
    tick();
    check("st_sym1", sym_o, 2'b01);
    tick();
    check("st_sym2", sym_o, 2'b11);
    sym_valid_i = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
